// File: rtl/sys_cmd_pkg.sv
// sys_cmd_pkg: shared constants and types for the command initiator.
// Opcode bytes, request encodings, FSM states and frame lengths.
package sys_cmd_pkg;

  localparam logic [7:0] OPC_WR  = 8'hAA;
  localparam logic [7:0] OPC_RD  = 8'hBB;
  localparam logic [7:0] OPC_ALU = 8'hCC;
  localparam logic [7:0] OPC_ALN = 8'hDD;

  localparam logic [1:0] OP_WR  = 2'b00;
  localparam logic [1:0] OP_RD  = 2'b01;
  localparam logic [1:0] OP_ALU = 2'b10;
  localparam logic [1:0] OP_ALN = 2'b11;

  localparam logic [2:0] LEN_WR  = 3'd3;
  localparam logic [2:0] LEN_RD  = 3'd2;
  localparam logic [2:0] LEN_ALU = 3'd4;
  localparam logic [2:0] LEN_ALN = 3'd2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

endpackage

// File: rtl/sys_cmd_timer.sv
// sys_cmd_timer: clearable up-counter for the response wait.
// tc flags the final cycle of the wait window.
module sys_cmd_timer #(
  parameter int TIMEOUT_CYCLES = 65535,
  parameter int TIMEOUT_W      = 16
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 clr,
  input  logic                 en,
  output logic [TIMEOUT_W-1:0] cnt,
  output logic                 tc
);

  localparam logic [TIMEOUT_W-1:0] LAST =
    TIMEOUT_W'(TIMEOUT_CYCLES - 1);

  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tc = en && (cnt == LAST);

endmodule

// File: rtl/sys_cmd_master.sv
// sys_cmd_master: serialises one command frame to UART TX and
// returns the single response byte from UART RX, or a timeout.
module sys_cmd_master #(
  parameter int DATA_WIDTH     = 8,
  parameter int ADDR_WIDTH     = 4,
  parameter int TIMEOUT_CYCLES = 65535,
  parameter int TIMEOUT_W      = 16
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [1:0]            req_op,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_data,
  input  logic [DATA_WIDTH-1:0] req_opa,
  input  logic [DATA_WIDTH-1:0] req_opb,
  input  logic [3:0]            req_fun,
  output logic [DATA_WIDTH-1:0] tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  input  logic [DATA_WIDTH-1:0] rx_data,
  input  logic                  rx_valid,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic                  rsp_timeout,
  output logic                  busy
);

  import sys_cmd_pkg::*;

  typedef logic [DATA_WIDTH-1:0] byte_t;

  state_t state_q, state_d;
  logic [1:0] idx_q, idx_d;
  logic [2:0] len_q, len_d;
  byte_t frame_q [4];
  byte_t frame_d [4];
  logic  rsp_valid_d;
  byte_t rsp_data_d;
  logic  rsp_to_d;
  logic  rst_q;
  logic  last;
  logic  tc;
  logic  in_wait;
  logic [TIMEOUT_W-1:0] cnt;

  assign in_wait = (state_q == ST_WAIT);

  sys_cmd_timer #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .TIMEOUT_W      (TIMEOUT_W)
  ) u_timer (
    .CLK (CLK),
    .RST (RST),
    .clr (!in_wait),
    .en  (in_wait),
    .cnt (cnt),
    .tc  (tc)
  );

  // Hold req_ready low for one cycle after reset is released.
  always_ff @(posedge CLK) begin
    rst_q <= RST;
  end

  assign req_ready = (state_q == ST_IDLE) && !rst_q;
  assign busy      = (state_q == ST_SEND) || in_wait;
  assign tx_valid  = (state_q == ST_SEND);
  assign tx_data   = tx_valid ? frame_q[idx_q] : '0;
  assign last      = ({1'b0, idx_q} == (len_q - 3'd1));

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    len_d       = len_q;
    frame_d     = frame_q;
    rsp_valid_d = 1'b0;
    rsp_data_d  = rsp_data;
    rsp_to_d    = rsp_timeout;
    unique case (state_q)
      ST_IDLE: begin
        if (req_valid && req_ready) begin
          state_d    = ST_SEND;
          idx_d      = 2'd0;
          frame_d[3] = '0;
          unique case (req_op)
            OP_WR: begin
              frame_d[0] = DATA_WIDTH'(OPC_WR);
              frame_d[1] = DATA_WIDTH'(req_addr);
              frame_d[2] = req_data;
              len_d      = LEN_WR;
            end
            OP_RD: begin
              frame_d[0] = DATA_WIDTH'(OPC_RD);
              frame_d[1] = DATA_WIDTH'(req_addr);
              frame_d[2] = '0;
              len_d      = LEN_RD;
            end
            OP_ALU: begin
              frame_d[0] = DATA_WIDTH'(OPC_ALU);
              frame_d[1] = req_opa;
              frame_d[2] = req_opb;
              frame_d[3] = DATA_WIDTH'(req_fun);
              len_d      = LEN_ALU;
            end
            default: begin
              frame_d[0] = DATA_WIDTH'(OPC_ALN);
              frame_d[1] = DATA_WIDTH'(req_fun);
              frame_d[2] = '0;
              len_d      = LEN_ALN;
            end
          endcase
        end
      end
      ST_SEND: begin
        if (tx_ready) begin
          if (last) begin
            state_d = ST_WAIT;
            idx_d   = 2'd0;
          end else begin
            idx_d = idx_q + 2'd1;
          end
        end
      end
      ST_WAIT: begin
        if (rx_valid) begin
          state_d     = ST_IDLE;
          rsp_valid_d = 1'b1;
          rsp_data_d  = rx_data;
          rsp_to_d    = 1'b0;
        end else if (tc) begin
          state_d     = ST_IDLE;
          rsp_valid_d = 1'b1;
          rsp_data_d  = '0;
          rsp_to_d    = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      len_q       <= '0;
      frame_q     <= '{default: '0};
      rsp_valid   <= 1'b0;
      rsp_data    <= '0;
      rsp_timeout <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      len_q       <= len_d;
      frame_q     <= frame_d;
      rsp_valid   <= rsp_valid_d;
      rsp_data    <= rsp_data_d;
      rsp_timeout <= rsp_to_d;
    end
  end

endmodule

// File: tb/tb_sys_cmd_master.sv
// tb_sys_cmd_master: directed checks of framing, response,
// timeout, stray rx and mid-frame reset.
module tb_sys_cmd_master;

  localparam int TO = 16;

  logic       CLK = 1'b0;
  logic       RST;
  logic       req_valid;
  logic       req_ready;
  logic [1:0] req_op;
  logic [3:0] req_addr;
  logic [7:0] req_data;
  logic [7:0] req_opa;
  logic [7:0] req_opb;
  logic [3:0] req_fun;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rsp_valid;
  logic [7:0] rsp_data;
  logic       rsp_timeout;
  logic       busy;

  int n_chk = 0;
  int n_err = 0;

  sys_cmd_master #(
    .DATA_WIDTH     (8),
    .ADDR_WIDTH     (4),
    .TIMEOUT_CYCLES (TO),
    .TIMEOUT_W      (16)
  ) dut (
    .CLK         (CLK),
    .RST         (RST),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_op      (req_op),
    .req_addr    (req_addr),
    .req_data    (req_data),
    .req_opa     (req_opa),
    .req_opb     (req_opb),
    .req_fun     (req_fun),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rsp_valid   (rsp_valid),
    .rsp_data    (rsp_data),
    .rsp_timeout (rsp_timeout),
    .busy        (busy)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag,
                     input logic [15:0] got,
                     input logic [15:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  logic [7:0] alu_b [4];

  initial begin
    RST = 1'b1; req_valid = 0; req_op = 0;
    req_addr = 0; req_data = 0; req_opa = 0;
    req_opb = 0; req_fun = 0; tx_ready = 0;
    rx_data = 0; rx_valid = 0;
    alu_b[0] = 8'hCC; alu_b[1] = 8'h12;
    alu_b[2] = 8'h34; alu_b[3] = 8'h01;
    ticks(3);
    chk("rst_ready", req_ready, 0);
    chk("rst_txv", tx_valid, 0);
    chk("rst_txd", tx_data, 0);
    chk("rst_rspv", rsp_valid, 0);
    chk("rst_rspd", rsp_data, 0);
    chk("rst_rspt", rsp_timeout, 0);
    chk("rst_busy", busy, 0);
    RST = 1'b0;
    tick();
    chk("ready_up", req_ready, 1);

    // write 5 <= 3C, tx_ready always high
    req_valid = 1; req_op = 2'b00;
    req_addr = 4'h5; req_data = 8'h3C; tx_ready = 1;
    tick();
    req_valid = 0; req_addr = 4'hF; req_data = 8'hEE;
    chk("wr_b0", tx_data, 8'hAA);
    chk("wr_v0", tx_valid, 1);
    chk("wr_busy", busy, 1);
    chk("wr_rdy", req_ready, 0);
    tick();
    chk("wr_b1", tx_data, 8'h05);
    tick();
    chk("wr_b2", tx_data, 8'h3C);
    tick();
    chk("wr_txv_off", tx_valid, 0);
    chk("wr_wait_busy", busy, 1);
    rx_valid = 1; rx_data = 8'h3C;
    tick();
    rx_valid = 0; rx_data = 8'h00;
    chk("wr_rspv", rsp_valid, 1);
    chk("wr_rspd", rsp_data, 8'h3C);
    chk("wr_rspt", rsp_timeout, 0);
    chk("wr_rdy_back", req_ready, 1);
    chk("wr_busy_off", busy, 0);
    tick();
    chk("wr_rspv_pulse", rsp_valid, 0);
    chk("wr_rspd_hold", rsp_data, 8'h3C);

    // ALU CC,12,34,01 with tx_ready toggling
    tx_ready = 0;
    req_valid = 1; req_op = 2'b10;
    req_opa = 8'h12; req_opb = 8'h34; req_fun = 4'h1;
    tick();
    req_valid = 0; req_opa = 0; req_opb = 0; req_fun = 0;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("alu_b%0d", i), tx_data, alu_b[i]);
      tx_ready = 0;
      tick();
      chk($sformatf("alu_hold%0d", i), tx_data, alu_b[i]);
      chk($sformatf("alu_v%0d", i), tx_valid, 1);
      tx_ready = 1;
      tick();
    end
    chk("alu_txv_off", tx_valid, 0);
    rx_valid = 1; rx_data = 8'h22;
    tick();
    rx_valid = 0;
    chk("alu_rspv", rsp_valid, 1);
    chk("alu_rspd", rsp_data, 8'h22);
    chk("alu_rspt", rsp_timeout, 0);

    // read addr 2, no response -> timeout
    req_valid = 1; req_op = 2'b01; req_addr = 4'h2;
    tick();
    req_valid = 0;
    chk("rd_b0", tx_data, 8'hBB);
    tick();
    chk("rd_b1", tx_data, 8'h02);
    tick();
    ticks(TO - 1);
    chk("to_early", rsp_valid, 0);
    chk("to_busy", busy, 1);
    tick();
    chk("to_rspv", rsp_valid, 1);
    chk("to_rspt", rsp_timeout, 1);
    chk("to_rspd", rsp_data, 0);
    chk("to_rdy", req_ready, 1);

    // rx_valid on the terminal cycle wins
    req_valid = 1; req_op = 2'b01; req_addr = 4'h2;
    tick();
    req_valid = 0;
    ticks(2);
    ticks(TO - 1);
    chk("tc_early", rsp_valid, 0);
    rx_valid = 1; rx_data = 8'h5A;
    tick();
    rx_valid = 0;
    chk("tc_rspv", rsp_valid, 1);
    chk("tc_rspd", rsp_data, 8'h5A);
    chk("tc_rspt", rsp_timeout, 0);

    // DD,03 with stray rx during SEND
    tx_ready = 0;
    req_valid = 1; req_op = 2'b11; req_fun = 4'h3;
    tick();
    req_valid = 0;
    chk("aln_b0", tx_data, 8'hDD);
    rx_valid = 1; rx_data = 8'h99;
    tick();
    rx_valid = 0;
    chk("stray_rspv", rsp_valid, 0);
    chk("stray_b0", tx_data, 8'hDD);
    chk("stray_busy", busy, 1);
    tx_ready = 1;
    tick();
    chk("aln_b1", tx_data, 8'h03);
    tick();
    chk("aln_txv_off", tx_valid, 0);
    ticks(3);
    chk("aln_wait", rsp_valid, 0);
    rx_valid = 1; rx_data = 8'h07;
    req_valid = 1; req_op = 2'b00;
    req_addr = 4'h1; req_data = 8'h77;
    tick();
    rx_valid = 0;
    chk("aln_rspv", rsp_valid, 1);
    chk("aln_rspd", rsp_data, 8'h07);
    chk("b2b_rdy", req_ready, 1);
    tick();
    req_valid = 0;
    chk("b2b_b0", tx_data, 8'hAA);
    chk("b2b_busy", busy, 1);

    // reset after the second byte of the AA frame
    tick();
    chk("b2b_b1", tx_data, 8'h01);
    tick();
    chk("b2b_b2", tx_data, 8'h77);
    RST = 1;
    tick();
    chk("abort_txv", tx_valid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_rdy", req_ready, 0);
    chk("abort_rspv", rsp_valid, 0);
    chk("abort_rspd", rsp_data, 0);
    RST = 0;
    tick();
    chk("abort_rdy_up", req_ready, 1);
    chk("abort_no_rsp", rsp_valid, 0);
    chk("abort_idle_txv", tx_valid, 0);

    // new read completes normally
    req_valid = 1; req_op = 2'b01; req_addr = 4'h3;
    tick();
    req_valid = 0;
    chk("rd2_b0", tx_data, 8'hBB);
    tick();
    chk("rd2_b1", tx_data, 8'h03);
    tick();
    ticks(2);
    rx_valid = 1; rx_data = 8'hA5;
    tick();
    rx_valid = 0;
    chk("rd2_rspv", rsp_valid, 1);
    chk("rd2_rspd", rsp_data, 8'hA5);
    chk("rd2_rspt", rsp_timeout, 0);

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/sys_cmd_master.md
# sys_cmd_master

Host-side command initiator for the register-file/ALU command protocol spoken by the system controller. It takes one request at a time (register write, register read, ALU op with operands, ALU op without operands), serialises the matching byte frame toward the UART transmitter, then waits for the single response byte from the UART receiver and returns it, or flags a timeout. It sits between a test/host sequencer and the UART TX/RX pair at the far end of the serial link.

## Interface
- DATA_WIDTH, 8, frame byte and response width
- ADDR_WIDTH, 4, register-file address width, ≤ DATA_WIDTH
- TIMEOUT_CYCLES, 65535, max cycles to wait for a response byte
- TIMEOUT_W, 16, timer width; TIMEOUT_CYCLES < 2^TIMEOUT_W

Ports:
- CLK  in  1  single clock; reset is synchronous and active-high
- RST  in  1  synchronous active-high reset
- req_valid  in  1  request strobe
- req_ready  out  1  block idle, request accepted when req_valid && req_ready at posedge
- req_op  in  2  00 write, 01 read, 10 ALU with operands, 11 ALU no operands
- req_addr  in  ADDR_WIDTH  register address (write/read)
- req_data  in  DATA_WIDTH  write data
- req_opa, req_opb  in  DATA_WIDTH  ALU operands A, B
- req_fun  in  4  ALU function code
- tx_data  out  DATA_WIDTH  byte to UART TX
- tx_valid  out  1  tx_data valid
- tx_ready  in  1  UART TX accepts byte
- rx_data  in  DATA_WIDTH  byte from UART RX
- rx_valid  in  1  one-cycle strobe, rx_data valid
- rsp_valid  out  1  one-cycle response strobe
- rsp_data  out  DATA_WIDTH  response byte (0 on timeout)
- rsp_timeout  out  1  qualifies rsp_valid: no response received
- busy  out  1  high in SEND and WAIT_RSP

## Operation
- Frames (byte 0 first): write = AA, addr, data; read = BB, addr; ALU = CC, A, B, fun; ALU no-op = DD, fun. addr and fun zero-extended to DATA_WIDTH.
- On accept, all frame bytes and frame length (3/2/4/2) are registered; req_* inputs are don't-care afterwards.
- States: IDLE → SEND on accept; SEND → WAIT_RSP on transfer of the last byte; WAIT_RSP → IDLE on rx_valid or timeout.
- SEND: tx_data = frame[idx], tx_valid = 1; byte transfers at posedge with tx_valid && tx_ready; idx increments; tx_data/tx_valid stable while tx_ready low.
- WAIT_RSP: timer cleared on entry, increments each cycle. rx_valid → rsp_data = rx_data, rsp_timeout = 0. Timer reaching TIMEOUT_CYCLES−1 without rx_valid → rsp_data = 0, rsp_timeout = 1. rx_valid on that same cycle wins (normal response).
- rx_valid in IDLE or SEND is discarded; no effect on state.
- Every command, including write, produces exactly one rsp_valid pulse.

## Timing
- Reset values: req_ready 0, tx_valid 0, tx_data 0, rsp_valid 0, rsp_data 0, rsp_timeout 0, busy 0; state IDLE, idx 0, timer 0. req_ready goes 1 the cycle after RST is sampled low.
- Accept at edge N: req_ready 0, busy 1, tx_valid 1 with byte 0 from cycle N+1.
- tx_ready held high: one byte per cycle; 4-byte frame occupies cycles N+1..N+4.
- Response rx_valid sampled at edge M: rsp_valid/rsp_data/rsp_timeout valid in cycle M+1 only; req_ready 1 and busy 0 in M+1, so a new request is accepted at edge M+1 (back-to-back).
- Timeout: rsp_valid exactly TIMEOUT_CYCLES cycles after the last byte's transfer edge.
- rsp_data/rsp_timeout hold their last value between pulses; only rsp_valid qualifies them.
- RST mid-frame or mid-wait: abort at that edge, all outputs to reset values next cycle, no rsp_valid for the aborted request.

## Structure
- Package sys_cmd_pkg: opcode byte constants (0xAA, 0xBB, 0xCC, 0xDD), req_op encodings, state encoding, frame-length constants.
- One sub-module, sys_cmd_timer: clearable up-counter, TIMEOUT_W wide, with terminal-count output at TIMEOUT_CYCLES−1.

## Test plan
- Write addr 0x5, data 0x3C, tx_ready always 1 → bytes AA,05,3C on consecutive cycles; rx 0x3C → rsp_valid 1 cycle later, rsp_data 0x3C, rsp_timeout 0.
- ALU A=0x12, B=0x34, fun=0x1, tx_ready toggling 1/0 → bytes CC,12,34,01 each held stable until tx_ready; rx 0x22 → rsp_data 0x22.
- Read addr 0x2, no rx, TIMEOUT_CYCLES=16 → rsp_valid with rsp_timeout 1, rsp_data 0, 16 cycles after BB,02 sent; rx_valid on the terminal cycle instead → normal response.
- Stray rx_valid during SEND of a DD,03 frame → ignored; later rx 0x07 in WAIT_RSP is the response; second request accepted on the rsp_valid cycle.
- RST asserted after the second byte of an AA frame → tx_valid 0 next cycle, no rsp_valid; req_ready 1 the cycle after RST drops; new read completes normally.
